// File: rtl/mas16_pkg.sv
// Shared definitions for the 16-bit line server: FSM encoding and line geometry.
package mas16_pkg;

    localparam int WORD_W     = 16;
    localparam int LINE_WORDS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BEAT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

endpackage

// File: rtl/mem16b_line_server_if.sv
// Cache-side request/response bus of the line server.
interface mem16b_line_server_if;
    import mas16_pkg::*;

    logic              req;
    logic              we;
    logic [15:0]       addr;
    logic [WORD_W-1:0] data_in;
    logic              busy;
    logic              rvalid;
    logic [WORD_W-1:0] mem_out;
    logic              ack;

    modport master (
        output req, we, addr, data_in,
        input  busy, rvalid, mem_out, ack
    );

    modport slave (
        input  req, we, addr, data_in,
        output busy, rvalid, mem_out, ack
    );
endinterface

// File: rtl/mem16b_store.sv
// Backing store: 2^AW x 16 words, synchronous write, asynchronous read, no reset.
module mem16b_store
    import mas16_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [2**AW];

    // Commit a word on the clock edge when the write enable is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem16b_line_server.sv
// Line server: accepts one cache request at a time, waits LATENCY cycles,
// then returns a two-beat line (read) or commits one word (write).
module mem16b_line_server
    import mas16_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rstz,
    mem16b_line_server_if.slave   bus,
    inout  wire                   dvdd,
    inout  wire                   dgnd
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [AW-1:0]     cap_addr_r, cap_addr_s;
    logic              cap_we_r, cap_we_s;
    logic [WORD_W-1:0] cap_data_r, cap_data_s;

    logic              busy_r, busy_s;
    logic              rvalid_r, rvalid_s;
    logic              ack_r, ack_s;
    logic [WORD_W-1:0] mem_out_r, mem_out_s;

    logic [AW-1:0]     rd_addr_s;
    logic [WORD_W-1:0] rd_data_s;
    logic              store_we_s;

    // Supply pins and the ignored upper address bits carry no logic.
    logic              unused_pins_s;
    assign unused_pins_s = ^{dvdd, dgnd, bus.addr};

    // Word address within the captured line for the given beat.
    function automatic logic [AW-1:0] line_word_addr(input logic [AW-1:0] a, input logic odd);
        return {a[AW-1:1], odd};
    endfunction

    mem16b_store #(.AW(AW)) u_store (
        .clk   (clk),
        .we    (store_we_s),
        .waddr (cap_addr_r),
        .wdata (cap_data_r),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Write commits on the edge leaving WRITE; reset clears the state first, so no commit.
    assign store_we_s = (state_r == ST_WRITE);

    // Next-state, counter and capture logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cap_addr_s = cap_addr_r;
        cap_we_s   = cap_we_r;
        cap_data_s = cap_data_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    cap_addr_s = bus.addr[AW-1:0];
                    cap_we_s   = bus.we;
                    cap_data_s = bus.data_in;
                    cnt_s      = CNT_LOAD;
                    state_s    = ST_WAIT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else if (cap_we_r) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_BEAT0;
                end
            end
            ST_BEAT0: state_s = ST_BEAT1;
            ST_BEAT1: state_s = ST_IDLE;
            ST_WRITE: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state, registered below.
    always_comb begin
        busy_s    = (state_s != ST_IDLE);
        rvalid_s  = 1'b0;
        ack_s     = 1'b0;
        mem_out_s = 16'h0000;
        rd_addr_s = line_word_addr(cap_addr_r, (state_s == ST_BEAT1));
        case (state_s)
            ST_BEAT0, ST_BEAT1: begin
                rvalid_s  = 1'b1;
                mem_out_s = rd_data_s;
            end
            ST_WRITE: ack_s = 1'b1;
            default: begin
                rvalid_s  = 1'b0;
                mem_out_s = 16'h0000;
            end
        endcase
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            cap_addr_r <= '0;
            cap_we_r   <= 1'b0;
            cap_data_r <= 16'h0000;
            busy_r     <= 1'b0;
            rvalid_r   <= 1'b0;
            ack_r      <= 1'b0;
            mem_out_r  <= 16'h0000;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cap_addr_r <= cap_addr_s;
            cap_we_r   <= cap_we_s;
            cap_data_r <= cap_data_s;
            busy_r     <= busy_s;
            rvalid_r   <= rvalid_s;
            ack_r      <= ack_s;
            mem_out_r  <= mem_out_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.ack     = ack_r;
    assign bus.mem_out = mem_out_r;

endmodule

// File: tb/tb_mem16b_line_server.sv
// Directed + randomized bench for mem16b_line_server with a word-array reference model.
module tb_mem16b_line_server;

    localparam int LAT = 3;

    logic clk  = 1'b0;
    logic rstz = 1'b0;
    wire  dvdd = 1'b1;
    wire  dgnd = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] known_q [$];

    mem16b_line_server_if bus ();

    mem16b_line_server #(.AW(8), .LATENCY(LAT)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus),
        .dvdd (dvdd),
        .dgnd (dgnd)
    );

    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_busy"}, bus.busy, 1'b0);
        check1({tag, "_rvalid"}, bus.rvalid, 1'b0);
        check1({tag, "_ack"}, bus.ack, 1'b0);
        check16({tag, "_mem_out"}, bus.mem_out, 16'h0000);
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.req     = 1'b1;
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
    endtask

    // Cycle k after the accepting edge: WAIT for k<=LAT, beats at LAT+1 and LAT+2, IDLE at LAT+3.
    task automatic read_body(input string tag, input logic [15:0] a, input bit hold, input logic [15:0] a2);
        logic [7:0]  ev;
        logic [7:0]  od;
        logic [15:0] exp_d;
        ev = {a[7:1], 1'b0};
        od = {a[7:1], 1'b1};
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            exp_d = (k == LAT + 1) ? ref_mem[ev] : (k == LAT + 2) ? ref_mem[od] : 16'h0000;
            check1({tag, "_busy"}, bus.busy, (k <= LAT + 2) ? 1'b1 : 1'b0);
            check1({tag, "_rvalid"}, bus.rvalid, (k == LAT + 1 || k == LAT + 2) ? 1'b1 : 1'b0);
            check1({tag, "_ack"}, bus.ack, 1'b0);
            check16({tag, "_mem_out"}, bus.mem_out, exp_d);
            if (k == 1) begin
                bus.req     = hold;
                bus.we      = hold ? 1'b0 : 1'($urandom);
                bus.addr    = 16'($urandom);
                bus.data_in = 16'($urandom);
            end
            if (k == 2 && hold) begin
                bus.addr = a2;
            end
        end
    endtask

    // WAIT for k<=LAT, ack at LAT+1, IDLE at LAT+2; the word lands in the model afterwards.
    task automatic write_body(input string tag, input logic [15:0] a, input logic [15:0] d);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            check1({tag, "_busy"}, bus.busy, (k <= LAT + 1) ? 1'b1 : 1'b0);
            check1({tag, "_ack"}, bus.ack, (k == LAT + 1) ? 1'b1 : 1'b0);
            check1({tag, "_rvalid"}, bus.rvalid, 1'b0);
            check16({tag, "_mem_out"}, bus.mem_out, 16'h0000);
            if (k == 1) begin
                bus.req     = 1'b0;
                bus.we      = 1'($urandom);
                bus.addr    = 16'($urandom);
                bus.data_in = 16'($urandom);
            end
        end
        ref_mem[a[7:0]] = d;
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        issue(1'b1, a, d);
        write_body(tag, a, d);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a);
        issue(1'b0, a, 16'h0000);
        read_body(tag, a, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rd;
        bus.req     = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = 16'h0000;
        bus.data_in = 16'h0000;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");

        // First request accepted on the first edge after reset release.
        rstz = 1'b1;
        do_write("wr10", 16'h0010, 16'hAAAA);
        do_write("wr11", 16'h0011, 16'h5555);
        do_read("rd11", 16'h0011);

        do_write("wr20", 16'h0020, 16'h1234);
        do_write("wr21", 16'h0021, 16'h0F0F);
        do_read("rd20", 16'h0020);

        // Held req with address change mid-WAIT, then chained read of 0x0040.
        do_write("wr40", 16'h0040, 16'hC0DE);
        do_write("wr41", 16'h0041, 16'h7E57);
        issue(1'b0, 16'h0011, 16'h0000);
        read_body("hold11", 16'h0011, 1'b1, 16'h0040);
        read_body("chain40", 16'h0040, 1'b0, 16'h0000);

        // Upper address bits ignored.
        do_write("wr30", 16'h0030, 16'h1111);
        do_write("wr31", 16'h0031, 16'h2222);
        do_read("rdFF31", 16'hFF31);
        do_read("rd0031", 16'h0031);

        // Reset during BEAT0 of a read.
        issue(1'b0, 16'h0010, 16'h0000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.req = 1'b0;
        end
        check1("beat0_pre_rvalid", bus.rvalid, 1'b1);
        check16("beat0_pre_data", bus.mem_out, ref_mem[8'h10]);
        rstz = 1'b0;
        #1;
        check_idle_outputs("rst_beat0");
        @(negedge clk);
        check_idle_outputs("rst_beat0_hold");
        rstz = 1'b1;
        do_read("post_rst_rd20", 16'h0021);

        // Reset during WRITE: the word must not be committed.
        issue(1'b1, 16'h0030, 16'hBEEF);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.req = 1'b0;
        end
        check1("write_pre_ack", bus.ack, 1'b1);
        rstz = 1'b0;
        #1;
        check_idle_outputs("rst_write");
        @(negedge clk);
        rstz = 1'b1;
        do_read("rd30_old", 16'h0030);

        // Randomized full-line writes followed by reads with random upper bits.
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rd = 16'($urandom);
            do_write("rnd_wr_a", ra, rd);
            do_write("rnd_wr_b", ra ^ 16'h0001, ~rd);
            known_q.push_back(ra);
        end
        for (int i = 0; i < 12; i++) begin
            ra = known_q[$urandom_range(0, known_q.size() - 1)];
            ra = {8'($urandom), ra[7:0]};
            do_read("rnd_rd", ra);
        end

        @(negedge clk);
        check_idle_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem16b_line_server.md
MEM16B_LINE_SERVER -- requirements
Module: mem16b_line_server

Interface
REQ-001 Parameter AW, default 8, log2 of backing-store depth in 16-bit words.
REQ-002 Parameter LATENCY, default 3, WAIT-state cycles before data or write commit; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rstz  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  request strobe from cache; sampled only in IDLE.
REQ-006 we  input  1  1 = word write, 0 = line read; sampled with req.
REQ-007 addr  input  16  word address from cache (addr_mem side).
REQ-008 data_in  input  16  write data from cache (data_mem side).
REQ-009 busy  output  1  high in every non-IDLE state.
REQ-010 rvalid  output  1  high while mem_out carries a read beat.
REQ-011 mem_out  output  16  read beat data; drives cache mem_in.
REQ-012 ack  output  1  one-cycle pulse on write commit.
REQ-013 dvdd, dgnd  inout  1  supply pins; no logic function.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, BEAT0, BEAT1 and WRITE.
REQ-015 In IDLE with req=1, the block SHALL capture addr, we and data_in, load cnt=LATENCY-1 and enter WAIT at the same edge.
REQ-016 In WAIT, cnt!=0 SHALL decrement; cnt==0 SHALL go to BEAT0 if captured we=0, else WRITE, so WAIT lasts exactly LATENCY cycles.
REQ-017 Store index SHALL be captured addr[AW-1:0]; addr[15:AW] SHALL be ignored.
REQ-018 BEAT0 SHALL drive rvalid=1 and mem_out=store[{addr[AW-1:1],1'b0}]; the next state SHALL be BEAT1.
REQ-019 BEAT1 SHALL drive rvalid=1 and mem_out=store[{addr[AW-1:1],1'b1}]; the next state SHALL be IDLE.
REQ-020 The first read beat SHALL appear LATENCY+1 cycles after the accepting edge; a read occupies LATENCY+2 cycles in total.
REQ-021 WRITE SHALL drive ack=1 for exactly one cycle and commit data_in to store[addr[AW-1:0]] on the edge leaving WRITE; the next state SHALL be IDLE.
REQ-022 Outside BEAT0 and BEAT1, rvalid SHALL be 0 and mem_out SHALL be 16'h0000; outside WRITE, ack SHALL be 0.
REQ-023 A req asserted while busy=1 SHALL be ignored with no queuing; the requester SHALL hold req until it observes busy=0.
REQ-024 Back-to-back requests: a req present in the IDLE cycle following BEAT1 or WRITE SHALL be accepted.
REQ-025 A read issued after a write to the same line SHALL return the new data.
REQ-026 Changes on addr, we or data_in after the accepting edge SHALL NOT affect the request in flight.

Reset
REQ-027 rstz=0 SHALL asynchronously force IDLE, cnt=0, busy=0, rvalid=0, ack=0 and mem_out=0, including mid-WAIT, mid-beat or in WRITE.
REQ-028 A write in progress when reset asserts SHALL NOT be committed.
REQ-029 Store contents SHALL NOT be reset and are undefined until written.
REQ-030 The first request SHALL be accepted on the first posedge after rstz deasserts.

Structure
REQ-031 Shared package mas16_pkg SHALL hold the FSM state encoding (3-bit) and the line geometry constants (WORD_W=16, LINE_WORDS=2).
REQ-032 The backing store SHALL be the sub-module mem16b_store: a 2^AW x 16 array with synchronous write, asynchronous read and no reset.
REQ-033 The FSM, latency counter and capture registers SHALL reside in mem16b_line_server.

Verification
REQ-034 With LATENCY=3, pre-load store[0x10]=0xAAAA and store[0x11]=0x5555; req read addr=0x0011 -> busy for 5 cycles, rvalid beats 0xAAAA then 0x5555 on cycles 4 and 5 after acceptance.
REQ-035 Write addr=0x0020, data=0x1234 -> ack pulse on cycle 4; then read addr=0x0020 -> beats 0x1234 then store[0x21].
REQ-036 Hold req high through a read and change addr to 0x0040 mid-WAIT -> original line returned, then a second read of 0x0040 accepted the cycle after BEAT1.
REQ-037 Assert rstz=0 during BEAT0 of a read -> rvalid, busy and mem_out drop to 0 asynchronously; the next request completes normally.
REQ-038 Assert rstz=0 in WRITE of addr=0x0030 with data 0xBEEF -> ack=0 and a later read shows the old store[0x30].
REQ-039 Read addr=0xFF31 with AW=8 -> same data as a read of addr=0x0031 (upper bits ignored).
